// File: rtl/alu_exec_pkg.sv
// Shared op codes, funct encodings, ALUOp values and FSM state type for alu_exec_ctrl.
package alu_exec_pkg;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_XOR  = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SLL  = 3'b011;
  localparam logic [2:0] ALU_SRAI = 3'b100;
  localparam logic [2:0] ALU_ADDI = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_MUL  = 3'b111;

  localparam logic [9:0] F_AND  = 10'b0000000111;
  localparam logic [9:0] F_XOR  = 10'b0000000100;
  localparam logic [9:0] F_SLL  = 10'b0000000001;
  localparam logic [9:0] F_ADD  = 10'b0000000000;
  localparam logic [9:0] F_SUB  = 10'b0100000000;
  localparam logic [9:0] F_MUL  = 10'b0000001000;
  localparam logic [9:0] F_SRAI = 10'b0100000101;

  localparam logic [1:0] ALUOP_I = 2'b00;
  localparam logic [1:0] ALUOP_R = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } mul_state_e;

endpackage

// File: rtl/alu_exec_ctrl_seq_mul_unit.sv
// Iterative shift-add multiplier with fixed XLEN-cycle latency.
//   state   | meaning
//   ST_IDLE | waiting for start; busy_o low
//   ST_MUL  | one shift-add step per edge; done_o on the cnt == XLEN-1 edge
import alu_exec_pkg::*;

module seq_mul_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] product_o
);
  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW-1:0] LAST = SHW'(XLEN - 1);

  mul_state_e      state_q, state_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [XLEN-1:0] sum;

  // Next-state and datapath step; sum is the accumulator after this edge's step.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    done_o   = 1'b0;
    sum      = acc_q + (mplier_q[0] ? mcand_q : '0);
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d  = ST_MUL;
          mcand_d  = a_i;
          mplier_d = b_i;
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      ST_MUL: begin
        if (flush_i) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          acc_d    = sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            done_o  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Engine registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  assign busy_o    = (state_q == ST_MUL);
  assign product_o = sum;

endmodule

// File: rtl/alu_exec_ctrl.sv
// EX-stage ALU: decodes {funct7,funct3}/ALUOp, executes, registers the result.
import alu_exec_pkg::*;

module alu_exec_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic            flush_i,
  input  logic [9:0]      funct_i,
  input  logic [1:0]      ALUOp_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic [XLEN-1:0] result_o,
  output logic            valid_o,
  output logic [2:0]      ALUCtrl_o,
  output logic            illegal_o
);
  localparam int SHW = $clog2(XLEN);

  logic [2:0]      op;
  logic            illegal;
  logic [XLEN-1:0] alu_res;
  logic [SHW-1:0]  shamt;
  logic            accept;
  logic            mul_start, mul_busy, mul_done;
  logic [XLEN-1:0] mul_product;

  logic [XLEN-1:0] result_q, result_d;
  logic            valid_q, valid_d;
  logic            illegal_q, illegal_d;
  logic [2:0]      ctrl_q, ctrl_d;

  // Decode; ALUOp values other than I-type fall into the R-type table.
  always_comb begin
    op      = ALU_ADD;
    illegal = 1'b0;
    if (ALUOp_i == ALUOP_I) begin
      op = (funct_i == F_SRAI) ? ALU_SRAI : ALU_ADDI;
    end else begin
      case (funct_i)
        F_AND:   op = ALU_AND;
        F_XOR:   op = ALU_XOR;
        F_SLL:   op = ALU_SLL;
        F_ADD:   op = ALU_ADD;
        F_SUB:   op = ALU_SUB;
        F_MUL:   op = ALU_MUL;
        default: illegal = 1'b1;
      endcase
    end
  end

  assign shamt = rs2_i[SHW-1:0];

  // Single-cycle datapath.
  always_comb begin
    alu_res = '0;
    case (op)
      ALU_AND:  alu_res = rs1_i & rs2_i;
      ALU_XOR:  alu_res = rs1_i ^ rs2_i;
      ALU_ADD:  alu_res = rs1_i + rs2_i;
      ALU_ADDI: alu_res = rs1_i + rs2_i;
      ALU_SUB:  alu_res = rs1_i - rs2_i;
      ALU_SLL:  alu_res = rs1_i << shamt;
      ALU_SRAI: alu_res = $signed(rs1_i) >>> shamt;
      default:  alu_res = '0;
    endcase
  end

  assign accept = valid_i && !mul_busy && !flush_i;

  // Output register next-state; a mul completion and an acceptance never coincide.
  always_comb begin
    result_d  = result_q;
    valid_d   = 1'b0;
    illegal_d = 1'b0;
    ctrl_d    = ctrl_q;
    mul_start = 1'b0;
    if (mul_done) begin
      result_d = mul_product;
      valid_d  = 1'b1;
    end else if (accept) begin
      ctrl_d = op;
      if (!illegal && op == ALU_MUL) begin
        mul_start = 1'b1;
      end else begin
        valid_d   = 1'b1;
        illegal_d = illegal;
        result_d  = illegal ? '0 : alu_res;
      end
    end
  end

  // Output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      result_q  <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      ctrl_q    <= 3'b000;
    end else begin
      result_q  <= result_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      ctrl_q    <= ctrl_d;
    end
  end

  seq_mul_unit #(.XLEN(XLEN)) u_mul (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (mul_start),
    .flush_i   (flush_i),
    .a_i       (rs1_i),
    .b_i       (rs2_i),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  assign ready_o   = !mul_busy;
  assign result_o  = result_q;
  assign valid_o   = valid_q;
  assign illegal_o = illegal_q;
  assign ALUCtrl_o = ctrl_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl: vector table plus multi-cycle mul/flush/reset sequences.
module tb_alu_exec_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_i, valid_i, flush_i;
  logic [9:0]  funct_i;
  logic [1:0]  ALUOp_i;
  logic [31:0] rs1_i, rs2_i;
  logic        ready_o, valid_o, illegal_o;
  logic [31:0] result_o;
  logic [2:0]  ALUCtrl_o;

  int total = 0;
  int bad   = 0;

  alu_exec_ctrl #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .flush_i(flush_i), .funct_i(funct_i), .ALUOp_i(ALUOp_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .result_o(result_o), .valid_o(valid_o),
    .ALUCtrl_o(ALUCtrl_o), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  aluop;
    logic [9:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic [2:0]  exp_ctrl;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [1:0] aop, input logic [9:0] f,
                       input logic [31:0] a, input logic [31:0] b);
    ALUOp_i = aop; funct_i = f; rs1_i = a; rs2_i = b; valid_i = 1'b1;
  endtask

  initial begin
    int k;
    int seen;
    bit got, early;

    vecs[0]  = '{2'b10, 10'b0100000000, 32'd5,        32'd7,        32'hFFFFFFFE, 3'b110, 1'b0};
    vecs[1]  = '{2'b00, 10'b0100000101, 32'h80000000, 32'd4,        32'hF8000000, 3'b100, 1'b0};
    vecs[2]  = '{2'b00, 10'b0000000000, 32'd1,        32'hFFFFFFFF, 32'h00000000, 3'b101, 1'b0};
    vecs[3]  = '{2'b10, 10'b0000000010, 32'd9,        32'd9,        32'h00000000, 3'b010, 1'b1};
    vecs[4]  = '{2'b10, 10'b0000000001, 32'd1,        32'h21,       32'h00000002, 3'b011, 1'b0};
    vecs[5]  = '{2'b10, 10'b0000000111, 32'h0000F0F0, 32'h00000FF0, 32'h000000F0, 3'b000, 1'b0};
    vecs[6]  = '{2'b10, 10'b0000000100, 32'h000000A5, 32'h000000FF, 32'h0000005A, 3'b001, 1'b0};
    vecs[7]  = '{2'b10, 10'b0000000000, 32'd2,        32'd3,        32'd5,        3'b010, 1'b0};
    vecs[8]  = '{2'b01, 10'b0000000000, 32'd10,       32'd20,       32'd30,       3'b010, 1'b0};
    vecs[9]  = '{2'b11, 10'b0100000000, 32'd0,        32'd1,        32'hFFFFFFFF, 3'b110, 1'b0};
    vecs[10] = '{2'b00, 10'b0100000000, 32'd3,        32'd4,        32'd7,        3'b101, 1'b0};
    vecs[11] = '{2'b10, 10'b0000000001, 32'd1,        32'd31,       32'h80000000, 3'b011, 1'b0};
    vecs[12] = '{2'b00, 10'b0100000101, 32'h7FFFFFFF, 32'd31,       32'h00000000, 3'b100, 1'b0};

    rst_i = 1'b0; valid_i = 1'b0; flush_i = 1'b0;
    funct_i = '0; ALUOp_i = '0; rs1_i = '0; rs2_i = '0;
    step(); step();
    chk("rst result", result_o, 32'd0);
    chk("rst valid", {31'd0, valid_o}, 32'd0);
    chk("rst illegal", {31'd0, illegal_o}, 32'd0);
    chk("rst ctrl", {29'd0, ALUCtrl_o}, 32'd0);
    chk("rst ready", {31'd0, ready_o}, 32'd1);
    rst_i = 1'b1;

    // back-to-back single-cycle ops
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].aluop, vecs[i].funct, vecs[i].a, vecs[i].b);
      step();
      chk($sformatf("v%0d valid", i), {31'd0, valid_o}, 32'd1);
      chk($sformatf("v%0d result", i), result_o, vecs[i].exp_res);
      chk($sformatf("v%0d ctrl", i), {29'd0, ALUCtrl_o}, {29'd0, vecs[i].exp_ctrl});
      chk($sformatf("v%0d illegal", i), {31'd0, illegal_o}, {31'd0, vecs[i].exp_ill});
    end
    valid_i = 1'b0;
    step();
    chk("idle valid drop", {31'd0, valid_o}, 32'd0);
    chk("idle illegal drop", {31'd0, illegal_o}, 32'd0);

    // mul 7 * -3 with an add held on valid_i during busy
    drive(2'b10, 10'b0000001000, 32'd7, 32'hFFFFFFFD);
    step();
    chk("mul accept ready", {31'd0, ready_o}, 32'd0);
    chk("mul accept valid", {31'd0, valid_o}, 32'd0);
    chk("mul ctrl", {29'd0, ALUCtrl_o}, 32'd7);
    drive(2'b10, 10'b0000000000, 32'd2, 32'd3);
    k = 0; got = 0; early = 0;
    while (k < 100 && !got) begin
      step();
      k++;
      if (valid_o) got = 1;
      else if (ready_o) early = 1;
    end
    chk("mul done seen", {31'd0, got}, 32'd1);
    chk("mul latency", k, 32'd32);
    chk("mul ready early", {31'd0, early}, 32'd0);
    chk("mul result", result_o, 32'hFFFFFFEB);
    step();
    chk("held add valid", {31'd0, valid_o}, 32'd1);
    chk("held add result", result_o, 32'd5);
    chk("held add ctrl", {29'd0, ALUCtrl_o}, 32'd2);

    // mul flushed at cycle 10
    drive(2'b10, 10'b0000001000, 32'd6, 32'd9);
    step();
    valid_i = 1'b0;
    repeat (9) step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("flush ready", {31'd0, ready_o}, 32'd1);
    chk("flush valid", {31'd0, valid_o}, 32'd0);
    chk("flush result hold", result_o, 32'd5);
    seen = 0;
    repeat (40) begin step(); if (valid_o) seen++; end
    chk("flush no valid", seen, 32'd0);
    drive(2'b10, 10'b0000000000, 32'd2, 32'd3);
    step();
    valid_i = 1'b0;
    chk("post flush valid", {31'd0, valid_o}, 32'd1);
    chk("post flush result", result_o, 32'd5);
    chk("post flush ctrl", {29'd0, ALUCtrl_o}, 32'd2);

    // flush offered with an op in IDLE drops it
    drive(2'b10, 10'b0000000100, 32'hFF, 32'h0F);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0; valid_i = 1'b0;
    chk("idle flush valid", {31'd0, valid_o}, 32'd0);
    chk("idle flush ctrl", {29'd0, ALUCtrl_o}, 32'd2);

    // reset during mul cycle 5
    drive(2'b10, 10'b0000001000, 32'd3, 32'd5);
    step();
    valid_i = 1'b0;
    repeat (4) step();
    rst_i = 1'b0;
    step();
    chk("mid rst result", result_o, 32'd0);
    chk("mid rst valid", {31'd0, valid_o}, 32'd0);
    chk("mid rst illegal", {31'd0, illegal_o}, 32'd0);
    chk("mid rst ctrl", {29'd0, ALUCtrl_o}, 32'd0);
    chk("mid rst ready", {31'd0, ready_o}, 32'd1);
    rst_i = 1'b1;
    seen = 0;
    repeat (40) begin step(); if (valid_o) seen++; end
    chk("mid rst no valid", seen, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
